// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared definitions for PC redirect handling: redirect classes, controller
// states and the architectural reset vector.
package pc_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_DEC  = 2'd1,
        CLS_MIS  = 2'd2,
        CLS_EXC  = 2'd3
    } redir_class_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } redir_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'hbfc0_0000;

endpackage

// File: rtl/pc_redirect_ctrl_redirect_prio_sel.sv
// Fixed-priority redirect selector: exception > mispredict > decode redirect.
module redirect_prio_sel
    import pc_redirect_ctrl_pkg::*;
(
    input  logic         exc_valid,
    input  logic [31:0]  exc_target,
    input  logic         mis_valid,
    input  logic [31:0]  mis_target,
    input  logic         dec_valid,
    input  logic [31:0]  dec_target,
    output redir_class_e win_cls_o,
    output logic [31:0]  win_target_o
);

    always_comb begin
        win_cls_o    = CLS_NONE;
        win_target_o = 32'h0;
        if (exc_valid) begin
            win_cls_o    = CLS_EXC;
            win_target_o = exc_target;
        end else if (mis_valid) begin
            win_cls_o    = CLS_MIS;
            win_target_o = mis_target;
        end else if (dec_valid) begin
            win_cls_o    = CLS_DEC;
            win_target_o = dec_target;
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Steers redirects into the fetch PC register, buffering one while fetch is
// busy and dropping the wrong-path fetch response that returns meanwhile.
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exc_valid,
    input  logic [31:0]      exc_target,
    input  logic             mis_valid,
    input  logic [31:0]      mis_target,
    input  logic             dec_valid,
    input  logic [31:0]      dec_target,
    input  logic [31:0]      seq_pc,
    input  logic             fetch_busy,
    input  logic             fetch_resp_valid,
    output logic             pc_load,
    output logic [31:0]      pc_next,
    output logic             discard_resp,
    output logic             redirect_acc,
    output logic             pending,
    output logic [CNT_W-1:0] wait_cnt
);

    redir_state_e     state_q, state_d;
    redir_class_e     pend_class_q, pend_class_d;
    logic [31:0]      pend_target_q, pend_target_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    redir_class_e     win_cls;
    logic [31:0]      win_target;
    logic             has_win;
    logic             win_beats_pend;

    redirect_prio_sel u_prio_sel (
        .exc_valid    (exc_valid),
        .exc_target   (exc_target),
        .mis_valid    (mis_valid),
        .mis_target   (mis_target),
        .dec_valid    (dec_valid),
        .dec_target   (dec_target),
        .win_cls_o    (win_cls),
        .win_target_o (win_target)
    );

    assign has_win        = (win_cls != CLS_NONE);
    // Equal class also wins: a younger redirect of the same class is the newer truth.
    assign win_beats_pend = has_win && (win_cls >= pend_class_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pend_class_q  <= CLS_NONE;
            pend_target_q <= RESET_PC;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pend_class_q  <= pend_class_d;
            pend_target_q <= pend_target_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pend_class_d  = pend_class_q;
        pend_target_d = pend_target_q;
        pc_load       = 1'b0;
        pc_next       = has_win ? win_target : seq_pc;
        discard_resp  = 1'b0;
        redirect_acc  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                redirect_acc = has_win;
                if (!fetch_busy) begin
                    pc_load = 1'b1;
                end else if (has_win) begin
                    pend_class_d  = win_cls;
                    pend_target_d = win_target;
                    state_d       = ST_WAIT;
                end
            end
            ST_WAIT: begin
                redirect_acc = win_beats_pend;
                discard_resp = fetch_resp_valid;
                if (!fetch_busy) begin
                    pc_load      = 1'b1;
                    pc_next      = win_beats_pend ? win_target : pend_target_q;
                    pend_class_d = CLS_NONE;
                    state_d      = ST_IDLE;
                end else if (win_beats_pend) begin
                    pend_class_d  = win_cls;
                    pend_target_d = win_target;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == ST_WAIT && wait_cnt_q != {CNT_W{1'b1}}) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    assign pending  = (state_q == ST_WAIT);
    assign wait_cnt = wait_cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: directed cycles queue their expected
// outputs, a negedge monitor pops and compares them.
module tb_pc_redirect_ctrl;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             exc_valid, mis_valid, dec_valid;
    logic [31:0]      exc_target, mis_target, dec_target, seq_pc;
    logic             fetch_busy, fetch_resp_valid;
    logic             pc_load, discard_resp, redirect_acc, pending;
    logic [31:0]      pc_next;
    logic [CNT_W-1:0] wait_cnt;

    int checks   = 0;
    int failures = 0;

    // mask bits: 0 pc_load, 1 pc_next, 2 discard_resp, 3 redirect_acc, 4 pending, 5 wait_cnt
    typedef struct {
        string       nm;
        logic [5:0]  mask;
        logic        load;
        logic [31:0] nxt;
        logic        disc;
        logic        acc;
        logic        pend;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    pc_redirect_ctrl #(.CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .exc_valid        (exc_valid),
        .exc_target       (exc_target),
        .mis_valid        (mis_valid),
        .mis_target       (mis_target),
        .dec_valid        (dec_valid),
        .dec_target       (dec_target),
        .seq_pc           (seq_pc),
        .fetch_busy       (fetch_busy),
        .fetch_resp_valid (fetch_resp_valid),
        .pc_load          (pc_load),
        .pc_next          (pc_next),
        .discard_resp     (discard_resp),
        .redirect_acc     (redirect_acc),
        .pending          (pending),
        .wait_cnt         (wait_cnt)
    );

    always #5 clk = ~clk;

    function automatic void cmp(string nm, string fld, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s.%s got=%h expected=%h", nm, fld, got, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.mask[0]) cmp(e.nm, "pc_load",      {31'b0, pc_load},      {31'b0, e.load});
            if (e.mask[1]) cmp(e.nm, "pc_next",      pc_next,               e.nxt);
            if (e.mask[2]) cmp(e.nm, "discard_resp", {31'b0, discard_resp}, {31'b0, e.disc});
            if (e.mask[3]) cmp(e.nm, "redirect_acc", {31'b0, redirect_acc}, {31'b0, e.acc});
            if (e.mask[4]) cmp(e.nm, "pending",      {31'b0, pending},      {31'b0, e.pend});
            if (e.mask[5]) cmp(e.nm, "wait_cnt",     {16'b0, wait_cnt},     {16'b0, e.cnt});
        end
    end

    task automatic expect_out(string nm, logic [5:0] mask, logic load, logic [31:0] nxt,
                              logic disc, logic acc, logic pend, logic [15:0] cnt);
        exp_t e;
        e.nm = nm; e.mask = mask; e.load = load; e.nxt = nxt;
        e.disc = disc; e.acc = acc; e.pend = pend; e.cnt = cnt;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_req();
        exc_valid = 1'b0; mis_valid = 1'b0; dec_valid = 1'b0;
        fetch_resp_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        exc_target = 32'h0; mis_target = 32'h0; dec_target = 32'h0;
        seq_pc = 32'h0; fetch_busy = 1'b0;
        clr_req();
        step();
        seq_pc = 32'hbfc00004;
        expect_out("reset", 6'b111111, 1'b1, 32'hbfc00004, 1'b0, 1'b0, 1'b0, 16'd0);
        step();
        rst = 1'b0;

        // free fetch, no requests: sequential PC
        seq_pc = 32'hbfc00008;
        expect_out("idle_seq", 6'b111011, 1'b1, 32'hbfc00008, 1'b0, 1'b0, 1'b0, 16'd0);
        step();

        // all three requests at once: exception wins
        dec_valid = 1'b1; dec_target = 32'h80001000;
        mis_valid = 1'b1; mis_target = 32'h80002000;
        exc_valid = 1'b1; exc_target = 32'hbfc00380;
        expect_out("prio_all", 6'b011011, 1'b1, 32'hbfc00380, 1'b0, 1'b1, 1'b0, 16'd0);
        step();
        clr_req();

        // mispredict while busy, release after 3 busy cycles with a response in flight
        fetch_busy = 1'b1; mis_valid = 1'b1; mis_target = 32'h80002000;
        expect_out("busy_c0", 6'b001001, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 16'd0);
        step();
        mis_valid = 1'b0;
        expect_out("busy_c1", 6'b111101, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 16'd0);
        step();
        expect_out("busy_c2", 6'b111101, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 16'd1);
        step();
        fetch_busy = 1'b0; fetch_resp_valid = 1'b1;
        expect_out("release", 6'b111111, 1'b1, 32'h80002000, 1'b1, 1'b0, 1'b1, 16'd2);
        step();
        fetch_resp_valid = 1'b0; seq_pc = 32'h8000200c;
        expect_out("after_rel", 6'b110111, 1'b1, 32'h8000200c, 1'b0, 1'b0, 1'b0, 16'd3);
        step();

        // lower class ignored while waiting, higher class overwrites
        fetch_busy = 1'b1; mis_valid = 1'b1; mis_target = 32'h80002000;
        expect_out("ovr_c0", 6'b001001, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 16'd3);
        step();
        mis_valid = 1'b0; dec_valid = 1'b1; dec_target = 32'h80003000;
        expect_out("dec_ignored", 6'b111101, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 16'd3);
        step();
        dec_valid = 1'b0; exc_valid = 1'b1; exc_target = 32'hbfc00380;
        expect_out("exc_overwrite", 6'b111101, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 16'd4);
        step();
        exc_valid = 1'b0; fetch_busy = 1'b0;
        expect_out("exc_release", 6'b111111, 1'b1, 32'hbfc00380, 1'b0, 1'b0, 1'b1, 16'd5);
        step();
        expect_out("cnt_hold", 6'b110000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd6);
        step();

        // release with a lower-class request present uses the buffered target
        fetch_busy = 1'b1; mis_valid = 1'b1; mis_target = 32'h80004000;
        expect_out("low_c0", 6'b001001, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 16'd6);
        step();
        mis_valid = 1'b0; fetch_busy = 1'b0; dec_valid = 1'b1; dec_target = 32'h80005000;
        expect_out("low_release", 6'b111011, 1'b1, 32'h80004000, 1'b0, 1'b0, 1'b1, 16'd6);
        step();
        dec_valid = 1'b0;

        // busy with no request: nothing happens
        fetch_busy = 1'b1;
        expect_out("busy_idle", 6'b111101, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd7);
        step();

        // asynchronous reset in the middle of WAIT
        mis_valid = 1'b1; mis_target = 32'h80006000;
        step();
        mis_valid = 1'b0;
        expect_out("pre_async", 6'b010000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 16'd0);
        step();
        #2 rst = 1'b1;
        expect_out("async_rst", 6'b110001, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);
        step();
        rst = 1'b0; fetch_busy = 1'b0; seq_pc = 32'hbfc00010;
        expect_out("post_rst", 6'b110011, 1'b1, 32'hbfc00010, 1'b0, 1'b0, 1'b0, 16'd0);
        step();

        // wait counter saturation
        fetch_busy = 1'b1; exc_valid = 1'b1; exc_target = 32'hbfc00200;
        step();
        exc_valid = 1'b0;
        repeat ((1 << CNT_W) + 5) step();
        expect_out("sat_wait", 6'b110001, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 16'hffff);
        step();
        fetch_busy = 1'b0;
        expect_out("sat_release", 6'b110011, 1'b1, 32'hbfc00200, 1'b0, 1'b0, 1'b1, 16'hffff);
        step();
        expect_out("sat_nowrap", 6'b110000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'hffff);
        step();

        repeat (3) step();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d expected=0 entries left", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
